ifu_fetch: RTL and testbench

Instruction-fetch front end that produces the pc/instruction pair latched by the IF/ID pipeline register. It owns the fetch PC, runs a single-outstanding request/acknowledge handshake with instruction memory, and buffers one fetched instruction until IF/ID accepts it. It also applies branch and flush redirects, and discards any response that is in flight when a redirect arrives.

---
 rtl/ifu_fetch_if.sv | 29 ++
 rtl/ifu_fetch.sv | 169 ++++++++++++++++
 tb/tb_ifu_fetch.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Instruction-memory fetch channel: single-outstanding request/acknowledge.
// Latency: combinational wires only; no storage in the interface.
// Backpressure: requester holds imem_req/imem_addr stable until imem_ack.
//
// Ports (signals):
//   imem_req    requester -> memory  fetch request
//   imem_addr   requester -> memory  64-bit fetch address
//   imem_ack    memory -> requester  response strobe, data valid same cycle
//   imem_rdata  memory -> requester  32-bit instruction
interface ifu_fetch_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: owns the fetch PC, fetches one instruction at a time, buffers it for IF/ID.
// Latency: N+1 cycles from first imem_req cycle to buffer valid (N = cycles to ack); 1 instr / 2 cycles peak.
// Backpressure: buffer holds while stall[1]=1; no new fetch while stall[0]=1 (an outstanding request still completes).
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   stall[5:0]                ctrl stall vector; [0] blocks new fetch, [1]=0 means IF/ID takes pc_o/inst_o
//   flush, flush_pc           trap/exception redirect (priority over branch)
//   branch_valid, branch_target  taken-branch redirect
//   imem                      fetch channel (master side)
//   pc_o, inst_o              buffered pc/instruction (inst_o = 0 when empty)
//   branch_slot_end_o         first instruction fetched after a branch redirect
//   stallreq_o                buffer empty, ctrl must hold stage 1
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [63:0] flush_pc,
    input  logic        branch_valid,
    input  logic [63:0] branch_target,
    ifu_fetch_if.master imem,
    output logic [63:0] pc_o,
    output logic [31:0] inst_o,
    output logic        branch_slot_end_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [63:0] redir_pc_q, redir_pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [63:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic        buf_bse_q, buf_bse_d;
    logic        bse_pend_q, bse_pend_d;

    logic        redirect;
    logic [63:0] redir_tgt;
    logic        req;
    logic        ack;
    logic        stall_unused;

    // Only the two low stall bits concern the fetch stage.
    assign stall_unused = ^stall[5:2];

    assign redirect  = flush | branch_valid;
    // Instruction addresses are word aligned; drop the low bits of any target.
    assign redir_tgt = flush ? {flush_pc[63:2], 2'b00} : {branch_target[63:2], 2'b00};

    assign req = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    // An ack with no request outstanding is meaningless and ignored.
    assign ack = imem.imem_ack & req;

    // In DRAIN the old address stays on the bus until the stale response arrives;
    // the redirect target waits in redir_pc_q meanwhile.
    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        redir_pc_d  = redir_pc_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;
        buf_bse_d   = buf_bse_q;
        bse_pend_d  = bse_pend_q;

        // Common redirect effects: drop the buffer, arm branch-slot marker for branches only.
        if (redirect) begin
            buf_valid_d = 1'b0;
            bse_pend_d  = ~flush;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redir_tgt;
                end else if (!stall[0]) begin
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (redirect) begin
                    if (ack) begin
                        // Response belongs to the old path: discard and refetch at once.
                        fetch_pc_d = redir_tgt;
                        state_d    = stall[0] ? ST_IDLE : ST_REQ;
                    end else begin
                        redir_pc_d = redir_tgt;
                        state_d    = ST_DRAIN;
                    end
                end else if (ack) begin
                    buf_valid_d = 1'b1;
                    buf_pc_d    = fetch_pc_q;
                    buf_inst_d  = imem.imem_rdata;
                    buf_bse_d   = bse_pend_q;
                    bse_pend_d  = 1'b0;
                    fetch_pc_d  = fetch_pc_q + 64'd4;
                    state_d     = ST_FULL;
                end
            end

            ST_FULL: begin
                // A redirect wins over consumption; IF/ID squashes the instruction itself.
                if (redirect) begin
                    fetch_pc_d = redir_tgt;
                    state_d    = ST_IDLE;
                end else if (!stall[1]) begin
                    buf_valid_d = 1'b0;
                    state_d     = stall[0] ? ST_IDLE : ST_REQ;
                end
            end

            ST_DRAIN: begin
                if (ack) begin
                    // Stale data is dropped; the newest redirect target is the next fetch.
                    fetch_pc_d = redirect ? redir_tgt : redir_pc_q;
                    state_d    = stall[0] ? ST_IDLE : ST_REQ;
                end else if (redirect) begin
                    redir_pc_d = redir_tgt;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            redir_pc_q  <= 64'd0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= 64'd0;
            buf_inst_q  <= 32'd0;
            buf_bse_q   <= 1'b0;
            bse_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            redir_pc_q  <= redir_pc_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
            buf_bse_q   <= buf_bse_d;
            bse_pend_q  <= bse_pend_d;
        end
    end

    assign pc_o              = buf_pc_q;
    assign inst_o            = buf_valid_q ? buf_inst_q : 32'd0;
    assign branch_slot_end_o = buf_valid_q & buf_bse_q;
    assign stallreq_o        = ~buf_valid_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a scoreboard of expected buffered instructions.
// Latency: one call to cyc() advances exactly one clock.
// Backpressure: stall bits are driven per step by the sequence.
module tb_ifu_fetch;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        bse;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [63:0] flush_pc;
    logic        branch_valid;
    logic [63:0] branch_target;
    logic [63:0] pc_o;
    logic [31:0] inst_o;
    logic        branch_slot_end_o;
    logic        stallreq_o;

    ifu_fetch_if m_if ();

    ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .branch_valid      (branch_valid),
        .branch_target     (branch_target),
        .imem              (m_if),
        .pc_o              (pc_o),
        .inst_o            (inst_o),
        .branch_slot_end_o (branch_slot_end_o),
        .stallreq_o        (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    exp_t        sb[$];
    logic [63:0] exp_pc;
    logic        exp_bse;
    bit          in_drain;
    logic [63:0] drain_addr;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return {a[23:2], 10'h013};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Observe outputs (just after a falling edge), drive inputs, update the model, advance one clock.
    task automatic cyc(input bit ack, input bit s0, input bit s1,
                       input bit br, input logic [63:0] bt,
                       input bit fl, input logic [63:0] fp);
        exp_t e;
        bit   redir;
        redir = br | fl;

        if (m_if.imem_req)
            chk("imem_addr", m_if.imem_addr, in_drain ? drain_addr : exp_pc);

        if (stallreq_o) begin
            chk("inst_empty", {32'd0, inst_o}, 64'd0);
            chk("bse_empty", {63'd0, branch_slot_end_o}, 64'd0);
        end else if (sb.size() == 0) begin
            chk("buf_unexpected", {63'd0, stallreq_o}, 64'd1);
        end else begin
            e = sb[0];
            chk("pc_o", pc_o, e.pc);
            chk("inst_o", {32'd0, inst_o}, {32'd0, e.inst});
            chk("bse_o", {63'd0, branch_slot_end_o}, {63'd0, e.bse});
            if (!s1 || redir) void'(sb.pop_front());
        end

        stall         = {4'b0000, s1, s0};
        branch_valid  = br;
        branch_target = bt;
        flush         = fl;
        flush_pc      = fp;
        m_if.imem_ack   = ack;
        m_if.imem_rdata = mem(in_drain ? drain_addr : exp_pc);

        if (ack && m_if.imem_req) begin
            if (in_drain) begin
                in_drain = 1'b0;
            end else if (!redir) begin
                sb.push_back('{pc: exp_pc, inst: mem(exp_pc), bse: exp_bse});
                exp_bse = 1'b0;
                exp_pc  = exp_pc + 64'd4;
            end
        end else if (m_if.imem_req && redir && !in_drain) begin
            in_drain   = 1'b1;
            drain_addr = exp_pc;
        end
        if (redir) begin
            exp_pc  = (fl ? fp : bt) & ~64'h3;
            exp_bse = !fl;
        end

        @(negedge clk);
    endtask

    task automatic reset_outputs_check(input string tag);
        chk({tag, "_req"}, {63'd0, m_if.imem_req}, 64'd0);
        chk({tag, "_addr"}, m_if.imem_addr, RESET_PC);
        chk({tag, "_pc"}, pc_o, 64'd0);
        chk({tag, "_inst"}, {32'd0, inst_o}, 64'd0);
        chk({tag, "_bse"}, {63'd0, branch_slot_end_o}, 64'd0);
        chk({tag, "_stallreq"}, {63'd0, stallreq_o}, 64'd1);
    endtask

    initial begin
        rst             = 1'b1;
        stall           = 6'd0;
        flush           = 1'b0;
        flush_pc        = 64'd0;
        branch_valid    = 1'b0;
        branch_target   = 64'd0;
        m_if.imem_ack   = 1'b0;
        m_if.imem_rdata = 32'd0;
        exp_pc          = RESET_PC;
        exp_bse         = 1'b0;
        in_drain        = 1'b0;
        drain_addr      = 64'd0;

        @(negedge clk);
        @(negedge clk);
        reset_outputs_check("reset");
        rst = 1'b0;

        // First fetch with same-cycle ack.
        chk("idle_req", {63'd0, m_if.imem_req}, 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("first_req", {63'd0, m_if.imem_req}, 64'd1);
        chk("first_addr", m_if.imem_addr, RESET_PC);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("first_pc", pc_o, RESET_PC);
        chk("first_inst", {32'd0, inst_o}, 64'h13);
        chk("first_stallreq", {63'd0, stallreq_o}, 64'd0);

        // IF/ID stalled for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            chk("hold_req", {63'd0, m_if.imem_req}, 64'd0);
            cyc(0, 0, 1, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("after_hold_req", {63'd0, m_if.imem_req}, 64'd1);
        chk("after_hold_addr", m_if.imem_addr, 64'h8000_0004);

        // Peak throughput: REQ/FULL alternating.
        for (int i = 0; i < 3; i++) begin
            chk("peak_req", {63'd0, m_if.imem_req}, 64'd1);
            cyc(1, 0, 0, 0, 0, 0, 0);
            chk("peak_full", {63'd0, stallreq_o}, 64'd0);
            cyc(0, 0, 0, 0, 0, 0, 0);
        end

        // Branch while REQ, ack 3 cycles later: stale data dropped.
        cyc(0, 0, 0, 1, 64'h8000_0102, 0, 0);
        chk("drain_req", {63'd0, m_if.imem_req}, 64'd1);
        chk("drain_addr", m_if.imem_addr, 64'h8000_0010);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("br_addr", m_if.imem_addr, 64'h8000_0100);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("br_bse1", {63'd0, branch_slot_end_o}, 64'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("br_bse0", {63'd0, branch_slot_end_o}, 64'd0);
        chk("br_next_pc", pc_o, 64'h8000_0104);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Flush and branch together, with same-cycle ack in REQ.
        cyc(1, 0, 0, 1, 64'h8000_2000, 1, 64'h8000_1000);
        chk("flush_addr", m_if.imem_addr, 64'h8000_1000);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("flush_bse", {63'd0, branch_slot_end_o}, 64'd0);
        chk("flush_pc", pc_o, 64'h8000_1000);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // stall[0] rising after the request: request held until ack.
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("s0_req_held", {63'd0, m_if.imem_req}, 64'd1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("s0_addr_held", m_if.imem_addr, 64'h8000_1004);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("s0_full", {63'd0, stallreq_o}, 64'd0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("s0_idle_req", {63'd0, m_if.imem_req}, 64'd0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("s0_idle_req2", {63'd0, m_if.imem_req}, 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("s0_release_req", {63'd0, m_if.imem_req}, 64'd1);

        // Redirect in FULL coinciding with consumption.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 64'h8000_3000, 0, 0);
        chk("full_redir_req", {63'd0, m_if.imem_req}, 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("full_redir_addr", m_if.imem_addr, 64'h8000_3000);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("full_redir_bse", {63'd0, branch_slot_end_o}, 64'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Reset while in DRAIN, then late acks are ignored.
        cyc(0, 0, 0, 1, 64'h8000_4000, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_req", {63'd0, m_if.imem_req}, 64'd1);
        rst = 1'b1;
        #1;
        reset_outputs_check("async_rst");
        sb.delete();
        exp_pc   = RESET_PC;
        exp_bse  = 1'b0;
        in_drain = 1'b0;
        m_if.imem_ack = 1'b1;
        @(negedge clk);
        chk("rst_late_ack_req", {63'd0, m_if.imem_req}, 64'd0);
        m_if.imem_ack = 1'b0;
        rst = 1'b0;
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_stallreq", {63'd0, stallreq_o}, 64'd1);
        chk("post_rst_addr", m_if.imem_addr, RESET_PC);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_inst", {32'd0, inst_o}, 64'h13);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);

        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
